// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 core: shifts in key + XOR checksum, commits on match.
// Define KEY_LOCK_ONCE_EN to allow only one successful commit per reset.
module c432_key_loader #(
  parameter int unsigned KEY_W = 32,
  parameter int unsigned CHK_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_loaded,
  output logic             load_err,
  output logic             busy
);

  localparam int unsigned FRAME_W = KEY_W + CHK_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CHK_W-1:0] chk_q, chk_d;
  logic             loaded_q, loaded_d;
  logic             err_q, err_d;
  logic             start_ok;
  logic             accept;
  logic             last_bit;
  logic [CHK_W-1:0] fold;

`ifdef KEY_LOCK_ONCE_EN
  // A committed key locks out further loads until reset; failed loads never set key_loaded.
  assign start_ok = load_start & ~loaded_q;
`else
  assign start_ok = load_start;
`endif

  assign ser_ready = (state_q == StShift);
  assign busy      = (state_q != StIdle);
  assign accept    = ser_valid & ser_ready;
  assign last_bit  = (cnt_q == CNT_W'(FRAME_W - 1));

  always_comb begin
    fold = '0;
    for (int i = 0; i < int'(KEY_W / CHK_W); i++) begin
      fold = fold ^ shadow_q[i*CHK_W +: CHK_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    chk_d    = chk_q;
    key_d    = key_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d  = StShift;
          cnt_d    = '0;
          shadow_d = '0;
          chk_d    = '0;
          err_d    = 1'b0;
        end
      end
      StShift: begin
        // Restart wins over a bit presented in the same cycle.
        if (start_ok) begin
          cnt_d    = '0;
          shadow_d = '0;
          chk_d    = '0;
        end else if (accept) begin
          if (cnt_q < CNT_W'(KEY_W)) begin
            shadow_d = {shadow_q[KEY_W-2:0], ser_data};
          end else begin
            chk_d = {chk_q[CHK_W-2:0], ser_data};
          end
          cnt_d = cnt_q + 1'b1;
          if (last_bit) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (fold == chk_q) begin
          key_d    = shadow_q;
          loaded_d = 1'b1;
          err_d    = 1'b0;
        end else begin
          key_d    = '0;
          loaded_d = 1'b0;
          err_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
      chk_q    <= '0;
      key_q    <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      chk_q    <= chk_d;
      key_q    <= key_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  assign key_out    = key_q;
  assign key_loaded = loaded_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// Scoreboard bench for c432_key_loader: driver pushes expected commits, monitor checks them.
module tb_c432_key_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        ser_valid = 1'b0;
  logic        ser_data = 1'b0;
  logic        ser_ready;
  logic [31:0] key_out;
  logic        key_loaded;
  logic        load_err;
  logic        busy;

  c432_key_loader #(.KEY_W(32), .CHK_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_start(load_start),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .ser_ready (ser_ready),
    .key_out   (key_out),
    .key_loaded(key_loaded),
    .load_err  (load_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] key;
    logic        loaded;
    logic        err;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          errors = 0;
  logic [31:0] model_key = '0;
  logic        busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: key_out must hold while busy; each busy->idle drop pops one expected commit.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (busy) check("key_hold", key_out, model_key);
      if (busy_prev && !busy) begin
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_commit: got key 0x%08h, want no commit", key_out);
        end else begin
          mon_e = sb.pop_front();
          check("commit_key", key_out, mon_e.key);
          check("commit_loaded", 32'(key_loaded), 32'(mon_e.loaded));
          check("commit_err", 32'(load_err), 32'(mon_e.err));
          check("commit_cycle", cyc, mon_e.at);
          model_key = mon_e.key;
        end
      end
      busy_prev = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load_start = 1'b0;
    ser_valid = 1'b0;
    model_key = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Full frame: key then check byte, MSB first; commit expected two edges after last bit shows.
  task automatic send_frame(input logic [31:0] key, input logic [7:0] chk, input bit stall,
                            input bit exp_ok);
    logic [39:0] fr;
    exp_t        e;
    int          n;
    fr = {key, chk};
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 39; i >= 0; i--) begin
      if (stall && (i % 2 == 1)) begin
        ser_valid = 1'b0;
        tick();
      end
      ser_valid = 1'b1;
      ser_data = fr[i];
      n = 0;
      while (!ser_ready && n < 8) begin
        tick();
        n++;
      end
      if (!ser_ready) begin
        vectors++;
        errors++;
        $display("FAIL ser_ready_timeout: got 0, want 1 at bit %0d", i);
      end
      if (i == 0) begin
        e.key    = exp_ok ? key : 32'h0;
        e.loaded = exp_ok;
        e.err    = !exp_ok;
        e.at     = cyc + 2;
        sb.push_back(e);
      end
      tick();
    end
    ser_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle with stray ser_valid.
    do_reset();
    ser_valid = 1'b1;
    ser_data = 1'b1;
    repeat (5) tick();
    check("idle_key", key_out, 32'h0);
    check("idle_loaded", 32'(key_loaded), 0);
    check("idle_ready", 32'(ser_ready), 0);
    check("idle_err", 32'(load_err), 0);
    check("idle_busy", 32'(busy), 0);
    ser_valid = 1'b0;

    // Good load, back-to-back.
    send_frame(32'hA5C30F1E, 8'h77, 0, 1);
    drain();
    check("good_busy", 32'(busy), 0);

    // Bad checksum, then a good load clears the error.
    do_reset();
    send_frame(32'hA5C30F1E, 8'h76, 0, 0);
    drain();
    check("bad_err", 32'(load_err), 1);
    send_frame(32'hA5C30F1E, 8'h77, 0, 1);
    drain();
    check("retry_err", 32'(load_err), 0);
    check("retry_key", key_out, 32'hA5C30F1E);

    // Stalled good load.
    do_reset();
    send_frame(32'hA5C30F1E, 8'h77, 1, 1);
    drain();
    check("stall_key", key_out, 32'hA5C30F1E);

    // Abort after 20 ones; the restart cycle also presents a 1 that must be dropped.
    do_reset();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    ser_valid = 1'b1;
    ser_data = 1'b1;
    repeat (20) tick();
    send_frame(32'h12345678, 8'h08, 0, 1);
    drain();
    check("abort_key", key_out, 32'h12345678);

    // Reset mid-load after a committed key.
    do_reset();
    send_frame(32'hA5C30F1E, 8'h77, 0, 1);
    drain();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    ser_valid = 1'b1;
    ser_data = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("rst_key", key_out, 32'h0);
    check("rst_loaded", 32'(key_loaded), 0);
    check("rst_busy", 32'(busy), 0);
    model_key = '0;
    ser_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(ser_ready), 0);
    check("post_rst_busy", 32'(busy), 0);

    // Second load after a commit: locked out or accepted depending on build.
    do_reset();
    send_frame(32'hA5C30F1E, 8'h77, 0, 1);
    drain();
`ifdef KEY_LOCK_ONCE_EN
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("lock_ready", 32'(ser_ready), 0);
    check("lock_busy", 32'(busy), 0);
    ser_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ser_data = ((32'h12345678 >> (i % 32)) & 1) != 0;
      tick();
    end
    ser_valid = 1'b0;
    tick();
    tick();
    check("lock_ready_end", 32'(ser_ready), 0);
    check("lock_key", key_out, 32'hA5C30F1E);
    check("lock_loaded", 32'(key_loaded), 1);
`else
    send_frame(32'h12345678, 8'h08, 0, 1);
    drain();
    check("reload_key", key_out, 32'h12345678);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
